instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential instruction assembler, the encoding counterpart of the control-unit decoder.
- Accepts symbolic instruction descriptors (mnemonic code plus register and immediate fields) over a valid/ready stream.
- Emits 32-bit PA-RISC-subset words with byte addresses for preloading instruction memory (testbench and boot loader path).
- One registered output stage with full-throughput backpressure; auto-incrementing write address; sticky illegal-mnemonic flag.

Parameters:
ADDR_W, 9, width of out_addr (byte address)
BASE_ADDR, 0, address of first word after reset/clear; multiple of 4
PAD_ALIGN, 16, flush alignment in bytes; power of 2, >= 4 (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  sync pulse: drop pending output, address back to BASE_ADDR, clear err_illegal and word_count
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid & in_ready
in_mnem  in  5  mnemonic code (table below)
in_ra  in  5  source reg r1 / store data reg
in_rb  in  5  source reg r2 / base reg
in_rt  in  5  target reg
in_cond  in  3  condition field c
in_imm  in  21  immediate; displacement; for shifts imm[4:0]=pos, imm[9:5]=len
out_valid  out  1  out_word/out_addr valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_word
err_illegal  out  1  sticky: illegal mnemonic seen
word_count  out  ADDR_W  words emitted since reset/clear
flush  in  1  request NOP padding (optional feature)
flush_busy  out  1  padding in progress (optional feature)

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_word=0, out_addr=BASE_ADDR, err_illegal=0, word_count=0, flush_busy=0, FSM=RUN.
- in_ready = !out_valid | out_ready, forced 0 while flush_busy.
- Latency: legal descriptor accepted in cycle N appears on out_word/out_valid in cycle N+1. Back-to-back throughput is one word per clock.
- out_word and out_addr hold stable while out_valid & !out_ready.
- Address: starts at BASE_ADDR and advances by 4 when an output transfers. Wraps modulo 2^ADDR_W with no flag. word_count increments on each output transfer and wraps.
- Codes 0-7: ADD, ADDC, ADDL, SUB, SUBB, OR, XOR, AND. Encoding: {000010, rb, ra, cond, 0, ext6, 0, rt}. ext6 values: 011000, 011100, 101000, 010000, 010100, 001001, 001010, 001000.
- Codes 8-10 LDW/LDH/LDB (op 010010/010001/010000) and 14 LDO (001101): {op, rb, rt, 00, lse14}.
- Codes 11-13 STW/STH/STB (op 011010/011001/011000): {op, rb, ra, 00, lse14}.
- lse14 = {imm[12:0], imm[13]}.
- Code 15 LDIL: {001000, rt, imm[20:0]}. Code 16 BL: {111010, rt, imm[20:0]}.
- Codes 17/18 COMBT/COMBF (op 100000/100010): {op, rb, ra, cond, imm[10:0], 00}.
- Codes 19/20 ADDI/SUBI (op 101101/100101): {op, rb, rt, cond, 00, imm[9:0], imm[10]}.
- Codes 21/22/23 EXTRU/EXTRS/ZDEP: {op, rb, rt, cond, ext3, imm[4:0], imm[9:5]}. Op/ext3 pairs: 110100/110, 110100/111, 110101/010.
- Codes 24-31 are illegal. The descriptor is still accepted (handshake completes) but is not emitted. Address and count are unchanged; err_illegal sets next cycle.
- clear: highest priority after reset. A descriptor presented in the same cycle is dropped; in_ready is 0 during the clear cycle.
- Simultaneous output transfer and new accept: register reloads; out_valid stays 1.

Optional Feature:
- Macro INSTR_ENC_NOP_PAD_EN.
- Defined: FSM RUN/PAD.
  - flush pulse in RUN: if the next free address is already PAD_ALIGN-aligned, no action.
  - Otherwise enter PAD with flush_busy=1, emitting NOP words 32'h00000000 at successive addresses through the same handshake (word_count counts them).
  - Return to RUN after the word whose address+4 is aligned.
  - clear or reset aborts PAD.
- Undefined: flush ignored, flush_busy tied 0, no PAD state.

Test Plan:
- ADD ra=2 rb=3 rt=4 cond=0, out_ready=1 -> next cycle out_word=0x08620604, out_addr=0x000, word_count=1.
- LDW rb=1 rt=5 imm=0x3FFC (-4) -> out_word=0x48253FF9. Then STB rb=1 ra=5 imm=0 -> 0x60250000 at out_addr=0x004.
- out_ready low for 3 cycles with in_valid high -> out_word held constant, in_ready=0, no descriptor lost; throughput resumes at 1/clk.
- in_mnem=25 -> err_illegal=1 next cycle, out_valid stays 0, out_addr unchanged. clear -> err_illegal=0, word_count=0, address=BASE_ADDR.
- rst_n asserted mid-stream while out_valid=1 -> out_valid=0 immediately (async); after release, first word at BASE_ADDR.
- (INSTR_ENC_NOP_PAD_EN) 1 word emitted, then flush -> three 0x00000000 words at 0x004, 0x008, 0x00C; flush_busy falls after the 0x00C transfer.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Sequential instruction assembler. Symbolic descriptors (mnemonic code plus
// register/immediate fields) arrive on a valid/ready stream and leave as
// 32-bit PA-RISC-subset words tagged with an auto-incrementing byte address,
// ready to preload instruction memory. One registered output stage gives
// full-throughput backpressure. Illegal mnemonics (24-31) are consumed but
// not emitted and set a sticky error flag.
//
// Optional feature: define INSTR_ENC_NOP_PAD_EN to enable NOP padding. A flush
// pulse then pads the stream with 32'h0 words up to the next PAD_ALIGN-byte
// boundary. Without the macro, flush is ignored and flush_busy is tied low.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   clear           sync pulse: drop pending word, address/count/error reset
//   in_valid/ready  descriptor handshake
//   in_mnem         mnemonic code 0-31
//   in_ra/rb/rt     register fields
//   in_cond         condition field
//   in_imm          immediate / displacement / {len, pos} for shifts
//   out_valid/ready output word handshake
//   out_word        encoded instruction
//   out_addr        byte address of out_word (next free address when idle)
//   err_illegal     sticky illegal-mnemonic flag
//   word_count      words transferred since reset/clear (wraps)
//   flush           request NOP padding to the next alignment boundary
//   flush_busy      padding in progress
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int PAD_ALIGN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic [4:0]        in_rt,
    input  logic [2:0]        in_cond,
    input  logic [20:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] word_count,
    input  logic              flush,
    output logic              flush_busy
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    function automatic logic [31:0] encode(
        input logic [4:0]  mnem,
        input logic [4:0]  ra,
        input logic [4:0]  rb,
        input logic [4:0]  rt,
        input logic [2:0]  cond,
        input logic [20:0] imm
    );
        logic [13:0] lse;
        logic [5:0]  ext6;
        logic [31:0] w;
        // Low-sign-extended 14-bit displacement: sign bit moves to the LSB.
        lse  = {imm[12:0], imm[13]};
        ext6 = 6'b000000;
        w    = 32'h0;
        case (mnem)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: begin
                case (mnem[2:0])
                    3'd0:    ext6 = 6'b011000;
                    3'd1:    ext6 = 6'b011100;
                    3'd2:    ext6 = 6'b101000;
                    3'd3:    ext6 = 6'b010000;
                    3'd4:    ext6 = 6'b010100;
                    3'd5:    ext6 = 6'b001001;
                    3'd6:    ext6 = 6'b001010;
                    default: ext6 = 6'b001000;
                endcase
                w = {6'b000010, rb, ra, cond, 1'b0, ext6, 1'b0, rt};
            end
            5'd8:  w = {6'b010010, rb, rt, 2'b00, lse};
            5'd9:  w = {6'b010001, rb, rt, 2'b00, lse};
            5'd10: w = {6'b010000, rb, rt, 2'b00, lse};
            5'd11: w = {6'b011010, rb, ra, 2'b00, lse};
            5'd12: w = {6'b011001, rb, ra, 2'b00, lse};
            5'd13: w = {6'b011000, rb, ra, 2'b00, lse};
            5'd14: w = {6'b001101, rb, rt, 2'b00, lse};
            5'd15: w = {6'b001000, rt, imm};
            5'd16: w = {6'b111010, rt, imm};
            5'd17: w = {6'b100000, rb, ra, cond, imm[10:0], 2'b00};
            5'd18: w = {6'b100010, rb, ra, cond, imm[10:0], 2'b00};
            5'd19: w = {6'b101101, rb, rt, cond, 2'b00, imm[9:0], imm[10]};
            5'd20: w = {6'b100101, rb, rt, cond, 2'b00, imm[9:0], imm[10]};
            5'd21: w = {6'b110100, rb, rt, cond, 3'b110, imm[4:0], imm[9:5]};
            5'd22: w = {6'b110100, rb, rt, cond, 3'b111, imm[4:0], imm[9:5]};
            5'd23: w = {6'b110101, rb, rt, cond, 3'b010, imm[4:0], imm[9:5]};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    logic              valid_q, valid_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;

    logic xfer, accept, legal;
    logic [31:0] enc_word;

    assign xfer     = valid_q & out_ready;
    assign accept   = in_valid & in_ready;
    assign legal    = (in_mnem < 5'd24);
    assign enc_word = encode(in_mnem, in_ra, in_rb, in_rt, in_cond, in_imm);
    assign in_ready = !clear && !flush_busy && (!valid_q || out_ready);

`ifdef INSTR_ENC_NOP_PAD_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PAD_ALIGN - 1);
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_PAD = 1'b1;

    logic [0:0] state_q, state_d;
    assign flush_busy = (state_q == ST_PAD);
`else
    logic unused_flush;
    assign unused_flush = flush ^ PAD_ALIGN[0];
    assign flush_busy   = 1'b0;
`endif

    // addr_q names the word in the register while valid, otherwise the next
    // free slot; it only moves when a word leaves, so it stays put on stalls.
    always_comb begin
        valid_d = valid_q & ~xfer;
        word_d  = word_q;
        addr_d  = xfer ? (addr_q + ADDR_STEP) : addr_q;
        count_d = count_q + ADDR_W'(xfer);
        err_d   = err_q | (accept & ~legal);
        if (accept && legal) begin
            valid_d = 1'b1;
            word_d  = enc_word;
        end
`ifdef INSTR_ENC_NOP_PAD_EN
        state_d = state_q;
        if (state_q == ST_PAD) begin
            // The last NOP is the one whose successor address is aligned.
            if (xfer && (((addr_q + ADDR_STEP) & ALIGN_MASK) == '0)) begin
                state_d = ST_RUN;
            end else if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                word_d  = 32'h0;
            end
        end else if (flush &&
                     (((addr_d + (valid_d ? ADDR_STEP : '0)) & ALIGN_MASK) != '0)) begin
            state_d = ST_PAD;
            // Start padding immediately if the register would otherwise idle.
            if (!valid_d) begin
                valid_d = 1'b1;
                word_d  = 32'h0;
            end
        end
`endif
        if (clear) begin
            valid_d = 1'b0;
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
`ifdef INSTR_ENC_NOP_PAD_EN
            state_d = ST_RUN;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= 32'h0;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef INSTR_ENC_NOP_PAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    assign out_valid   = valid_q;
    assign out_word    = word_q;
    assign out_addr    = addr_q;
    assign err_illegal = err_q;
    assign word_count  = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int ADDR_W    = 9;
    localparam int BASE_ADDR = 0;
    localparam int PAD_ALIGN = 16;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [4:0]        in_ra;
    logic [4:0]        in_rb;
    logic [4:0]        in_rt;
    logic [2:0]        in_cond;
    logic [20:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [ADDR_W-1:0] word_count;
    logic              flush;
    logic              flush_busy;

    instr_encoder #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .PAD_ALIGN(PAD_ALIGN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mnem(in_mnem),
        .in_ra(in_ra),
        .in_rb(in_rb),
        .in_rt(in_rt),
        .in_cond(in_cond),
        .in_imm(in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word(out_word),
        .out_addr(out_addr),
        .err_illegal(err_illegal),
        .word_count(word_count),
        .flush(flush),
        .flush_busy(flush_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: field values placed at their bit positions with
    // shifts, straight from the instruction format tables.
    function automatic logic [31:0] ref_enc(input int unsigned m, input int unsigned ra,
                                            input int unsigned rb, input int unsigned rt,
                                            input int unsigned c, input int unsigned imm);
        int unsigned ext6 [8];
        int unsigned ld_op [7];
        int unsigned lse;
        int unsigned w;
        ext6  = '{32'h18, 32'h1C, 32'h28, 32'h10, 32'h14, 32'h09, 32'h0A, 32'h08};
        ld_op = '{32'h12, 32'h11, 32'h10, 32'h1A, 32'h19, 32'h18, 32'h0D};
        lse   = ((imm & 32'h1FFF) << 1) | ((imm >> 13) & 1);
        w     = 0;
        if (m < 8)
            w = (2 << 26) | (rb << 21) | (ra << 16) | (c << 13) | (ext6[m] << 6) | rt;
        else if (m <= 14)
            w = (ld_op[m-8] << 26) | (rb << 21) | (((m >= 11 && m <= 13) ? ra : rt) << 16) | lse;
        else if (m == 15)
            w = (32'h08 << 26) | (rt << 21) | imm;
        else if (m == 16)
            w = (32'h3A << 26) | (rt << 21) | imm;
        else if (m <= 18)
            w = (((m == 17) ? 32'h20 : 32'h22) << 26) | (rb << 21) | (ra << 16) | (c << 13)
                | ((imm & 32'h7FF) << 2);
        else if (m <= 20)
            w = (((m == 19) ? 32'h2D : 32'h25) << 26) | (rb << 21) | (rt << 16) | (c << 13)
                | ((imm & 32'h3FF) << 1) | ((imm >> 10) & 1);
        else
            w = (((m == 23) ? 32'h35 : 32'h34) << 26) | (rb << 21) | (rt << 16) | (c << 13)
                | (((m == 21) ? 6 : (m == 22) ? 7 : 2) << 10) | ((imm & 31) << 5) | ((imm >> 5) & 31);
        return w;
    endfunction

    typedef struct {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
        bit                last;
    } exp_t;

    exp_t              sb [$];
    exp_t              e;
    logic [ADDR_W-1:0] m_addr;
    logic [ADDR_W-1:0] m_count;
    bit                m_err;
    bit                pad_active;
    bit                pad_was;
    bit                exp_rdy;

    // Monitor + model, on the falling edge: first compare the state left by
    // the last rising edge, then advance the model by the handshakes that the
    // next rising edge will complete.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_word", out_word, 32'd0);
            chk("rst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
            chk("rst_word_count", 32'(word_count), 32'd0);
            chk("rst_err_illegal", 32'(err_illegal), 32'd0);
            chk("rst_flush_busy", 32'(flush_busy), 32'd0);
            sb.delete();
            m_addr     = ADDR_W'(BASE_ADDR);
            m_count    = '0;
            m_err      = 1'b0;
            pad_active = 1'b0;
        end else begin
            pad_was = pad_active;
            exp_rdy = !clear && !pad_active && (sb.size() == 0 || out_ready);
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("word_count", 32'(word_count), 32'(m_count));
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
            chk("flush_busy", 32'(flush_busy), 32'(pad_active));
            if (sb.size() != 0) begin
                chk("out_word", out_word, sb[0].word);
                chk("out_addr", 32'(out_addr), 32'(sb[0].addr));
            end else begin
                chk("idle_addr", 32'(out_addr), 32'(m_addr));
            end
            if (clear) begin
                sb.delete();
                m_addr     = ADDR_W'(BASE_ADDR);
                m_count    = '0;
                m_err      = 1'b0;
                pad_active = 1'b0;
            end else begin
                if (sb.size() != 0 && out_ready) begin
                    e = sb.pop_front();
                    m_count = m_count + 1'b1;
                    if (e.last) pad_active = 1'b0;
                end
                if (in_valid && exp_rdy) begin
                    if (in_mnem < 24) begin
                        e.word = ref_enc(in_mnem, in_ra, in_rb, in_rt, in_cond, in_imm);
                        e.addr = m_addr;
                        e.last = 1'b0;
                        sb.push_back(e);
                        m_addr = m_addr + ADDR_W'(4);
                    end else begin
                        m_err = 1'b1;
                    end
                end
`ifdef INSTR_ENC_NOP_PAD_EN
                if (flush && !pad_was && (int'(m_addr) % PAD_ALIGN) != 0) begin
                    pad_active = 1'b1;
                    do begin
                        e.word = 32'h0;
                        e.addr = m_addr;
                        e.last = ((int'(m_addr) + 4) % PAD_ALIGN) == 0;
                        sb.push_back(e);
                        m_addr = m_addr + ADDR_W'(4);
                    end while ((int'(m_addr) % PAD_ALIGN) != 0);
                end
`endif
            end
        end
    end

    // Random consumer backpressure when enabled.
    bit rdy_rand = 1'b0;
    always @(posedge clk) begin
        #2;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_desc(input int m, input int ra, input int rb, input int rt,
                            input int c, input int imm);
        in_mnem = 5'(m);
        in_ra   = 5'(ra);
        in_rb   = 5'(rb);
        in_rt   = 5'(rt);
        in_cond = 3'(c);
        in_imm  = 21'(imm);
    endtask

    task automatic wait_acc();
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic send(input int m, input int ra, input int rb, input int rt,
                        input int c, input int imm);
        set_desc(m, ra, rb, rt, c, imm);
        in_valid = 1'b1;
        wait_acc();
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit allow_illegal);
        int m;
        if (allow_illegal && $urandom_range(0, 15) == 0) m = $urandom_range(24, 31);
        else m = $urandom_range(0, 23);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 32'h1FFFFF));
    endtask

    task automatic pulse_clear(input bit with_valid);
        if (with_valid) set_desc(0, 1, 1, 1, 0, 0);
        in_valid = with_valid;
        clear    = 1'b1;
        cyc(1);
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        set_desc(0, 0, 0, 0, 0, 0);
        cyc(3);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed encodings: ADD, LDW with negative displacement, STB.
        send(0, 2, 3, 4, 0, 0);
        send(8, 0, 1, 5, 0, 32'h3FFC);
        send(13, 5, 1, 0, 0, 0);
        cyc(2);

        // Backpressure: consumer stalls 3 cycles with a descriptor waiting.
        send(19, 1, 2, 3, 5, 32'h5A5);
        out_ready = 1'b0;
        set_desc(21, 0, 7, 9, 2, 32'h3E1);
        in_valid = 1'b1;
        cyc(3);
        out_ready = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) send_rand(1'b0);
        cyc(2);

        // Illegal mnemonic, then clear (with a descriptor that must be dropped).
        send(25, 3, 3, 3, 0, 0);
        cyc(2);
        pulse_clear(1'b1);
        cyc(2);

        // Randomized traffic with random backpressure, flushes and clears.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 2));
            if ($urandom_range(0, 30) == 0) pulse_flush();
            if ($urandom_range(0, 80) == 0) pulse_clear(1'b0);
            send_rand(1'b1);
        end
        rdy_rand = 1'b0;
        cyc(1);
        out_ready = 1'b1;
        cyc(12);

        // Asynchronous reset while a word is pending.
        out_ready = 1'b0;
        send_rand(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc(1);
        send_rand(1'b0);
        cyc(3);

        // Padding: one word emitted, then flush.
        pulse_clear(1'b0);
        send(2, 4, 5, 6, 1, 0);
        cyc(2);
        pulse_flush();
        cyc(8);
        send(3, 1, 2, 3, 0, 0);
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
